icache: RTL and testbench

Instruction-side line provider between the fetch stage and the system bus. It accepts a 64-byte-aligned line request from fetch and returns the whole 512-bit line with a one-cycle done pulse. When the storage option is compiled in, lines are held in a direct-mapped array. Misses are refilled from memory as eight 64-bit bus beats.

---
 rtl/icache_pkg.sv | 31 +++
 rtl/icache_fill_buffer.sv | 39 +++
 rtl/icache.sv | 176 +++++++++++++++++
 tb/tb_icache.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared types and constants for the instruction line cache.
package icache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_BUS_REQ,
    ST_BUS_RESP,
    ST_DONE
  } ic_state_e;

  localparam int LINE_BYTES = 64;
  localparam int BEAT_BITS  = 64;
  localparam int LINE_BITS  = LINE_BYTES * 8;
  localparam int NUM_BEATS  = LINE_BITS / BEAT_BITS;
  localparam int BEAT_CNT_W = $clog2(NUM_BEATS);
  localparam int OFFS_W     = $clog2(LINE_BYTES);

  // Bus request tag layout: {dir, type, id}
  localparam logic       BUS_READ   = 1'b1;
  localparam logic [3:0] BUS_MEMORY = 4'b0001;

  typedef struct packed {
    logic       dir;
    logic [3:0] kind;
    logic [7:0] id;
  } bus_tag_t;

  localparam bus_tag_t RD_TAG = '{dir: BUS_READ, kind: BUS_MEMORY, id: 8'd0};

endpackage

// File: rtl/icache_fill_buffer.sv
// ic_fill_buffer: counts refill beats and assembles them into one line.
// line_next already contains the beat arriving this cycle, so the owner can
// take the complete line on the last-beat edge without an extra cycle.
module ic_fill_buffer
  import icache_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  beat_valid,
  input  logic [BEAT_BITS-1:0]  beat_data,
  output logic [BEAT_CNT_W-1:0] beat_cnt,
  output logic [LINE_BITS-1:0]  line_next,
  output logic                  last_beat
);

  logic [NUM_BEATS-1:0][BEAT_BITS-1:0] line_q;

  assign last_beat = beat_valid && (beat_cnt == BEAT_CNT_W'(NUM_BEATS - 1));

  for (genvar k = 0; k < NUM_BEATS; k++) begin : g_lane
    assign line_next[k*BEAT_BITS +: BEAT_BITS] =
      (beat_valid && beat_cnt == BEAT_CNT_W'(k)) ? beat_data : line_q[k];
  end

  // beat k lands in slot k; counter wraps to zero after the last beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt <= '0;
      line_q   <= '0;
    end else if (clr) begin
      beat_cnt <= '0;
    end else if (beat_valid) begin
      line_q[beat_cnt] <= beat_data;
      beat_cnt         <= beat_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/icache.sv
// icache: fetch-side line provider. Returns a full 512-bit line per request
// with a single ic_done pulse; misses refill over eight 64-bit bus beats.
// Build option ICACHE_STORAGE_EN adds a direct-mapped tag/valid/data array;
// without it every request goes to the bus and flush is ignored.
module icache
  import icache_pkg::*;
#(
  parameter int SETS = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ic_enable,
  input  logic [63:0]  iaddr,
  output logic [511:0] idata,
  output logic         ic_done,
  input  logic         flush,
  output logic         bus_reqcyc,
  output logic [63:0]  bus_req,
  output logic [12:0]  bus_reqtag,
  input  logic         bus_reqack,
  input  logic         bus_respcyc,
  input  logic [63:0]  bus_resp,
  output logic         bus_respack
);

  localparam int LADDR_W = 64 - OFFS_W;
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_W   = LADDR_W - IDX_W;

  ic_state_e              state;
  logic [LADDR_W-1:0]     laddr_q;
  logic                   hit;
  logic [LINE_BITS-1:0]   hit_data;
  logic                   beat_valid;
  logic                   fill_clr;
  logic                   last_beat;
  logic [BEAT_CNT_W-1:0]  fill_cnt;
  logic [LINE_BITS-1:0]   fill_line;
  logic                   unused_offs;

  // Response beats are always accepted; stray ones are simply not assembled.
  assign bus_respack = bus_respcyc;
  assign beat_valid  = bus_respcyc && (state == ST_BUS_RESP);
  assign fill_clr    = (state == ST_BUS_REQ) && bus_reqack;
  assign unused_offs = ^iaddr[OFFS_W-1:0];

  ic_fill_buffer u_fill (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (fill_clr),
    .beat_valid (beat_valid),
    .beat_data  (bus_resp),
    .beat_cnt   (fill_cnt),
    .line_next  (fill_line),
    .last_beat  (last_beat)
  );

`ifdef ICACHE_STORAGE_EN
  localparam bit STORAGE = 1'b1;

  logic [TAG_W-1:0]     tag_arr  [SETS];
  logic [LINE_BITS-1:0] data_arr [SETS];
  logic [SETS-1:0]      valid_q;
  logic [TAG_W-1:0]     tag_rd;
  logic                 valid_rd;
  logic                 flush_seen;
  logic                 install;
  logic [IDX_W-1:0]     rd_idx;
  logic [IDX_W-1:0]     fill_idx;

  assign rd_idx   = iaddr[OFFS_W +: IDX_W];
  assign fill_idx = laddr_q[IDX_W-1:0];
  assign hit      = valid_rd && (tag_rd == laddr_q[LADDR_W-1:IDX_W]);
  // a flush anywhere during the fill (including the last-beat cycle) blocks install
  assign install  = last_beat && !flush_seen && !flush;

  // valid bits, registered valid lookup and the flush-during-fill marker
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= '0;
      valid_rd   <= 1'b0;
      flush_seen <= 1'b0;
    end else begin
      if (flush)        valid_q <= '0;
      else if (install) valid_q[fill_idx] <= 1'b1;
      if (state == ST_IDLE) begin
        if (ic_enable) begin
          valid_rd   <= valid_q[rd_idx] & ~flush;
          flush_seen <= flush;
        end
      end else if (flush) begin
        flush_seen <= 1'b1;
      end
    end
  end

  // tag/data arrays: read on request accept, written by a clean refill
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && ic_enable) begin
      tag_rd   <= tag_arr[rd_idx];
      hit_data <= data_arr[rd_idx];
    end
    if (install) begin
      tag_arr[fill_idx]  <= laddr_q[LADDR_W-1:IDX_W];
      data_arr[fill_idx] <= fill_line;
    end
  end
`else
  localparam bit STORAGE = 1'b0;

  logic unused_flush;
  assign unused_flush = flush;
  assign hit          = 1'b0;
  assign hit_data     = '0;
`endif

  // request FSM with registered bus request and completion outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      laddr_q    <= '0;
      ic_done    <= 1'b0;
      idata      <= '0;
      bus_reqcyc <= 1'b0;
      bus_req    <= '0;
      bus_reqtag <= '0;
    end else begin
      ic_done <= 1'b0;
      case (state)
        ST_IDLE: if (ic_enable) begin
          laddr_q <= iaddr[63:OFFS_W];
          if (STORAGE) begin
            state <= ST_LOOKUP;
          end else begin
            state      <= ST_BUS_REQ;
            bus_reqcyc <= 1'b1;
            bus_req    <= {iaddr[63:OFFS_W], {OFFS_W{1'b0}}};
            bus_reqtag <= RD_TAG;
          end
        end
        ST_LOOKUP: if (hit) begin
          idata <= hit_data;
          state <= ST_DONE;
        end else begin
          state      <= ST_BUS_REQ;
          bus_reqcyc <= 1'b1;
          bus_req    <= {laddr_q, {OFFS_W{1'b0}}};
          bus_reqtag <= RD_TAG;
        end
        ST_BUS_REQ: if (bus_reqack) begin
          bus_reqcyc <= 1'b0;
          state      <= ST_BUS_RESP;
        end
        ST_BUS_RESP: if (last_beat) begin
          idata <= fill_line;
          state <= ST_DONE;
        end
        ST_DONE: begin
          ic_done <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_stray_beat: assert property (@(posedge clk) disable iff (!reset_n)
    bus_respcyc |-> state == ST_BUS_RESP);
  a_busy_enable: assert property (@(posedge clk) disable iff (!reset_n)
    ic_enable |-> state == ST_IDLE);
  a_cnt_wrapped: assert property (@(posedge clk) disable iff (!reset_n)
    (state == ST_DONE) |-> fill_cnt == '0);
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed bench for icache with a cycle-level bus responder.
// Expectations adapt to whether ICACHE_STORAGE_EN is compiled in.
module tb_icache;

`ifdef ICACHE_STORAGE_EN
  localparam int S = 1;
`else
  localparam int S = 0;
`endif
  localparam logic [63:0] INC = 64'h0808080808080808;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         ic_enable = 1'b0;
  logic [63:0]  iaddr = '0;
  logic [511:0] idata;
  logic         ic_done;
  logic         flush = 1'b0;
  logic         bus_reqcyc;
  logic [63:0]  bus_req;
  logic [12:0]  bus_reqtag;
  logic         bus_reqack = 1'b0;
  logic         bus_respcyc = 1'b0;
  logic [63:0]  bus_resp = '0;
  logic         bus_respack;

  int n_cmp = 0;
  int n_fail = 0;

  // results of the last request
  int           r_lat, r_cyc, r_dones, r_ackerr;
  bit           r_req, r_unst;
  logic [63:0]  r_a;
  logic [12:0]  r_t;
  logic [511:0] r_line;

  icache #(.SETS(64)) dut (
    .clk(clk), .reset_n(reset_n), .ic_enable(ic_enable), .iaddr(iaddr),
    .idata(idata), .ic_done(ic_done), .flush(flush),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_respack(bus_respack)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] mk_line(input logic [63:0] base);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + 64'(k) * INC;
    return l;
  endfunction

  function automatic int lmiss(input int d, input int g);
    return S + d + 10 + 7 * g;
  endfunction

  // Issue one request and play the bus side; lat counts cycles after the enable edge.
  task automatic run_req(input logic [63:0] addr, input int ack_dly, input int gap,
                         input logic [63:0] base, input int flush_beat, input int rst_beat);
    int phase = 0, beat = 0, wait_n = 0, post = -1, rst_cnt = 0;
    r_lat = -1; r_cyc = 0; r_dones = 0; r_ackerr = 0; r_req = 0; r_unst = 0;
    r_a = '0; r_t = '0; r_line = '0;
    ic_enable = 1'b1; iaddr = addr;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      ic_enable = 1'b0; bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; flush = 1'b0;
      if (rst_cnt > 0) begin rst_cnt--; if (rst_cnt == 0) reset_n = 1'b1; end
      if (ic_done) begin
        r_dones++;
        if (r_lat < 0) begin r_lat = i; r_line = idata; end
        if (post < 0) post = 2;
      end
      if (phase == 1) begin phase = 2; wait_n = 0; end
      if (bus_reqcyc) begin
        if (!r_req) begin r_a = bus_req; r_t = bus_reqtag; end
        else if (bus_req !== r_a || bus_reqtag !== r_t) r_unst = 1;
        r_req = 1; r_cyc++;
        if (phase == 0 && r_cyc == ack_dly + 1) begin bus_reqack = 1'b1; phase = 1; end
      end
      if (phase == 2 && beat < 8) begin
        if (wait_n > 0) wait_n--;
        else if (beat == rst_beat) begin reset_n = 1'b0; rst_cnt = 2; beat = 8; post = 8; end
        else begin
          bus_respcyc = 1'b1; bus_resp = base + 64'(beat) * INC;
          if (beat == flush_beat) flush = 1'b1;
          beat++; wait_n = gap;
        end
      end
      #1;
      if (bus_respack !== bus_respcyc) r_ackerr++;
      if (post == 0) break;
      if (post > 0) post--;
    end
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ic_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", ic_done); end
    n_cmp++; if (idata !== '0) begin n_fail++; $display("FAIL rst_idata: got %h want 0", idata); end
    n_cmp++; if (bus_reqcyc !== 1'b0) begin n_fail++; $display("FAIL rst_reqcyc: got %b want 0", bus_reqcyc); end
    n_cmp++; if (bus_req !== '0) begin n_fail++; $display("FAIL rst_req: got %h want 0", bus_req); end
    n_cmp++; if (bus_reqtag !== '0) begin n_fail++; $display("FAIL rst_tag: got %h want 0", bus_reqtag); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_cold_miss();
    logic [511:0] exp;
    for (int i = 0; i < 64; i++) exp[i*8 +: 8] = 8'(i);
    run_req(64'h1000_0027, 0, 0, 64'h0706050403020100, -1, -1);
    n_cmp++; if (r_dones !== 1) begin n_fail++; $display("FAIL cold_dones: got %0d want 1", r_dones); end
    n_cmp++; if (r_lat !== lmiss(0, 0)) begin n_fail++; $display("FAIL cold_lat: got %0d want %0d", r_lat, lmiss(0, 0)); end
    n_cmp++; if (r_a !== 64'h1000_0000) begin n_fail++; $display("FAIL cold_req: got %h want 10000000", r_a); end
    n_cmp++; if (r_t !== 13'h1100) begin n_fail++; $display("FAIL cold_tag: got %h want 1100", r_t); end
    n_cmp++; if (r_cyc !== 1) begin n_fail++; $display("FAIL cold_reqcyc: got %0d want 1", r_cyc); end
    n_cmp++; if (r_line !== exp) begin n_fail++; $display("FAIL cold_line: got %h want %h", r_line, exp); end
    n_cmp++; if (r_ackerr !== 0) begin n_fail++; $display("FAIL cold_respack: got %0d errs want 0", r_ackerr); end
  endtask

  task automatic test_hit();
    logic [511:0] exp;
    exp = (S != 0) ? mk_line(64'h0706050403020100) : mk_line(64'hA0A1A2A3A4A5A6A7);
    run_req(64'h1000_0010, 0, 0, 64'hA0A1A2A3A4A5A6A7, -1, -1);
    n_cmp++; if (r_lat !== ((S != 0) ? 2 : lmiss(0, 0))) begin n_fail++; $display("FAIL hit_lat: got %0d want %0d", r_lat, (S != 0) ? 2 : lmiss(0, 0)); end
    n_cmp++; if (r_req !== (S == 0)) begin n_fail++; $display("FAIL hit_bus: got %b want %b", r_req, S == 0); end
    n_cmp++; if (r_dones !== 1) begin n_fail++; $display("FAIL hit_dones: got %0d want 1", r_dones); end
    n_cmp++; if (r_line !== exp) begin n_fail++; $display("FAIL hit_line: got %h want %h", r_line, exp); end
  endtask

  task automatic test_conflict();
    run_req(64'h1000_1000, 0, 0, 64'h1122334455667788, -1, -1);
    n_cmp++; if (!r_req || r_a !== 64'h1000_1000) begin n_fail++; $display("FAIL conf_req: got %b/%h want 1/10001000", r_req, r_a); end
    n_cmp++; if (r_line !== mk_line(64'h1122334455667788)) begin n_fail++; $display("FAIL conf_line: got %h", r_line); end
    run_req(64'h1000_0000, 0, 0, 64'h0706050403020100, -1, -1);
    n_cmp++; if (!r_req || r_lat !== lmiss(0, 0)) begin n_fail++; $display("FAIL conf_remiss: got req %b lat %0d want 1 %0d", r_req, r_lat, lmiss(0, 0)); end
    n_cmp++; if (r_line !== mk_line(64'h0706050403020100)) begin n_fail++; $display("FAIL conf_reline: got %h", r_line); end
    run_req(64'h1000_0000, 0, 0, 64'h3333000000000004, -1, -1);
    n_cmp++; if (r_req !== (S == 0)) begin n_fail++; $display("FAIL conf_rehit: got bus %b want %b", r_req, S == 0); end
    n_cmp++; if (r_line !== ((S != 0) ? mk_line(64'h0706050403020100) : mk_line(64'h3333000000000004))) begin n_fail++; $display("FAIL conf_hitline: got %h", r_line); end
  endtask

  task automatic test_slow_bus();
    run_req(64'h2000_0040, 5, 3, 64'h0F1E2D3C4B5A6978, -1, -1);
    n_cmp++; if (r_cyc !== 6) begin n_fail++; $display("FAIL slow_reqcyc: got %0d want 6", r_cyc); end
    n_cmp++; if (r_unst !== 1'b0) begin n_fail++; $display("FAIL slow_stable: got %b want 0", r_unst); end
    n_cmp++; if (r_a !== 64'h2000_0040) begin n_fail++; $display("FAIL slow_req: got %h want 20000040", r_a); end
    n_cmp++; if (r_lat !== lmiss(5, 3)) begin n_fail++; $display("FAIL slow_lat: got %0d want %0d", r_lat, lmiss(5, 3)); end
    n_cmp++; if (r_dones !== 1) begin n_fail++; $display("FAIL slow_dones: got %0d want 1", r_dones); end
    n_cmp++; if (r_line !== mk_line(64'h0F1E2D3C4B5A6978)) begin n_fail++; $display("FAIL slow_line: got %h", r_line); end
  endtask

  task automatic test_flush();
    run_req(64'h3000_0080, 0, 0, 64'hDEADBEEF00000000, 4, -1);
    n_cmp++; if (r_dones !== 1) begin n_fail++; $display("FAIL fl_dones: got %0d want 1", r_dones); end
    n_cmp++; if (r_line !== mk_line(64'hDEADBEEF00000000)) begin n_fail++; $display("FAIL fl_line: got %h", r_line); end
    run_req(64'h3000_0080, 0, 0, 64'h5555000012345678, -1, -1);
    n_cmp++; if (r_req !== 1'b1) begin n_fail++; $display("FAIL fl_nofill: got bus %b want 1", r_req); end
    n_cmp++; if (r_line !== mk_line(64'h5555000012345678)) begin n_fail++; $display("FAIL fl_refill: got %h", r_line); end
    // idle flush drops every cached line
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0; @(posedge clk); #1;
    run_req(64'h1000_0000, 0, 0, 64'h00000000CAFE0000, -1, -1);
    n_cmp++; if (r_req !== 1'b1 || r_line !== mk_line(64'h00000000CAFE0000)) begin n_fail++; $display("FAIL fl_idle_a: got bus %b line %h", r_req, r_line); end
    run_req(64'h3000_0080, 0, 0, 64'h7777666655554444, -1, -1);
    n_cmp++; if (r_req !== 1'b1 || r_line !== mk_line(64'h7777666655554444)) begin n_fail++; $display("FAIL fl_idle_b: got bus %b line %h", r_req, r_line); end
  endtask

  task automatic test_reset_midfill();
    run_req(64'h4000_00C0, 0, 0, 64'h8888000000000001, -1, 3);
    n_cmp++; if (r_dones !== 0) begin n_fail++; $display("FAIL mrst_dones: got %0d want 0", r_dones); end
    n_cmp++; if (ic_done !== 1'b0 || bus_reqcyc !== 1'b0) begin n_fail++; $display("FAIL mrst_ctl: got done %b reqcyc %b want 0 0", ic_done, bus_reqcyc); end
    n_cmp++; if (idata !== '0 || bus_req !== '0 || bus_reqtag !== '0) begin n_fail++; $display("FAIL mrst_data: got %h %h %h want 0", idata, bus_req, bus_reqtag); end
    run_req(64'h4000_00C0, 0, 0, 64'h9999000000000002, -1, -1);
    n_cmp++; if (r_dones !== 1 || r_lat !== lmiss(0, 0)) begin n_fail++; $display("FAIL mrst_next: got dones %0d lat %0d want 1 %0d", r_dones, r_lat, lmiss(0, 0)); end
    n_cmp++; if (r_line !== mk_line(64'h9999000000000002)) begin n_fail++; $display("FAIL mrst_line: got %h", r_line); end
    // reset also cleared the line cached before it
    run_req(64'h1000_0000, 0, 0, 64'hABCD000000000003, -1, -1);
    n_cmp++; if (r_req !== 1'b1 || r_line !== mk_line(64'hABCD000000000003)) begin n_fail++; $display("FAIL mrst_cold: got bus %b line %h", r_req, r_line); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_slow_bus();
    test_flush();
    test_reset_midfill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
